// File: rtl/matrix_feeder_if.sv
// Host-stream and PE-array signal bundle for the matrix feeder.
// The slave view belongs to the feeder; the master view drives it from the host/PE side.
interface matrix_feeder_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  start;
    logic [31:0]           cfg_depth;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            pe_state;
    logic                  ap_start;
    logic                  ap_ctrl;
    logic [31:0]           ap_matrix_depth;
    logic [DATA_WIDTH-1:0] col_data;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start,
        output cfg_depth,
        output in_data,
        output in_valid,
        output pe_state,
        input  in_ready,
        input  ap_start,
        input  ap_ctrl,
        input  ap_matrix_depth,
        input  col_data,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  cfg_depth,
        input  in_data,
        input  in_valid,
        input  pe_state,
        output in_ready,
        output ap_start,
        output ap_ctrl,
        output ap_matrix_depth,
        output col_data,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/matrix_feeder.sv
// Streams one job's C, A and B words from the host into the PE column inputs,
// then waits for the PE array to drain and re-initialise before taking the next job.
module matrix_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int ARRAY_SIZE = 16,
    parameter int MAX_DEPTH  = 8000
) (
    input  logic           clk,
    input  logic           rst,
    matrix_feeder_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_C,
        LOAD_A,
        LOAD_B,
        WAIT_OUT,
        WAIT_INIT
    } state_t;

    localparam logic [7:0] PE_INIT = 8'h01;
    localparam logic [7:0] PE_OUT  = 8'h80;

    state_t                state_q, state_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [31:0]           depth_q, depth_d;
    logic [DATA_WIDTH-1:0] col_q, col_d;
    logic                  ctrl_q, ctrl_d;
    logic                  apstart_q, apstart_d;
    logic                  err_q, err_d;

    logic                  loading;
    logic                  accept;
    logic                  depth_ok;
    logic                  last_word;
    logic                  done_c;
    logic [31:0]           phase_len;

    // in_ready comes from the state register alone so the host sees no in_valid loop
    always_comb begin
        loading   = (state_q == LOAD_C) || (state_q == LOAD_A) || (state_q == LOAD_B);
        accept    = loading && bus.in_valid;
        depth_ok  = (bus.cfg_depth != 32'd0) && (bus.cfg_depth <= 32'(MAX_DEPTH));
        phase_len = (state_q == LOAD_C) ? 32'(ARRAY_SIZE) : depth_q;
        last_word = (cnt_q == phase_len - 32'd1);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        depth_d   = depth_q;
        col_d     = col_q;
        ctrl_d    = accept;
        apstart_d = accept && (state_q == LOAD_C);
        err_d     = 1'b0;
        done_c    = 1'b0;

        if (accept) begin
            col_d = bus.in_data;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (depth_ok) begin
                        depth_d = bus.cfg_depth;
                        cnt_d   = 32'd0;
                        state_d = LOAD_C;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_C, LOAD_A, LOAD_B: begin
                if (accept) begin
                    if (last_word) begin
                        cnt_d = 32'd0;
                        case (state_q)
                            LOAD_C:  state_d = LOAD_A;
                            LOAD_A:  state_d = LOAD_B;
                            default: state_d = WAIT_OUT;
                        endcase
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            WAIT_OUT: begin
                if (bus.pe_state == PE_OUT) begin
                    state_d = WAIT_INIT;
                end
            end
            WAIT_INIT: begin
                if (bus.pe_state == PE_INIT) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 32'd0;
            depth_q   <= 32'd0;
            col_q     <= '0;
            ctrl_q    <= 1'b0;
            apstart_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            depth_q   <= depth_d;
            col_q     <= col_d;
            ctrl_q    <= ctrl_d;
            apstart_q <= apstart_d;
            err_q     <= err_d;
        end
    end

    assign bus.in_ready        = loading;
    assign bus.ap_start        = apstart_q;
    assign bus.ap_ctrl         = ctrl_q;
    assign bus.ap_matrix_depth = depth_q;
    assign bus.col_data        = col_q;
    assign bus.busy            = (state_q != IDLE);
    assign bus.done            = done_c;
    assign bus.err             = err_q;

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of every matrix word (10-18).
REQ-002 Parameter ARRAY_SIZE, default 16: number of PE rows, which is also the number of initial-C words per job.
REQ-003 Parameter MAX_DEPTH, default 8000: largest legal matrix depth.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-006 Port start, input, 1: job request; sampled only in IDLE.
REQ-007 Port cfg_depth, input, 32: matrix depth for the job; sampled with start.
REQ-008 Port in_data, input, DATA_WIDTH: host word stream, in C, then A, then B order.
REQ-009 Port in_valid, input, 1: in_data is valid.
REQ-010 Port in_ready, output, 1: the feeder accepts in_data this cycle.
REQ-011 Port pe_state, input, 8: one-hot state from the PE array (INIT=8'h01, OUT=8'h80).
REQ-012 Port ap_start, output, 1: job-start qualifier to the PE array.
REQ-013 Port ap_ctrl, output, 1: col_data carries a new word this cycle.
REQ-014 Port ap_matrix_depth, output, 32: latched job depth to the PE array.
REQ-015 Port col_data, output, DATA_WIDTH: word broadcast to the PE column inputs.
REQ-016 Port busy, output, 1: a job is in progress.
REQ-017 Port done, output, 1: one-cycle pulse at job completion.
REQ-018 Port err, output, 1: one-cycle pulse when start is rejected.

Function
REQ-019 The FSM SHALL use the states IDLE, LOAD_C, LOAD_A, LOAD_B, WAIT_OUT and WAIT_INIT.
REQ-020 In IDLE, start with 1<=cfg_depth<=MAX_DEPTH SHALL latch cfg_depth into ap_matrix_depth, clear the word counter, and go to LOAD_C.
REQ-021 In IDLE, start with cfg_depth==0 or cfg_depth>MAX_DEPTH SHALL pulse err for one cycle and remain in IDLE.
REQ-022 The start input SHALL be ignored outside IDLE.
REQ-023 in_ready SHALL be 1 exactly when the state is LOAD_C, LOAD_A or LOAD_B; it is decoded from the state register only, with no combinational path from in_valid.
REQ-024 A word is accepted in a cycle where in_valid and in_ready are both 1.
REQ-025 On an accepted word, the next cycle SHALL present col_data=in_data with ap_ctrl=1 (one-cycle latency).
REQ-026 Cycles with no accepted word SHALL drive ap_ctrl=0 and hold col_data at its previous value.
REQ-027 ap_start SHALL be 1 in every cycle where ap_ctrl is 1 for a LOAD_C word, and 0 otherwise.
REQ-028 LOAD_C SHALL accept exactly ARRAY_SIZE words, then go to LOAD_A.
REQ-029 LOAD_A SHALL accept exactly ap_matrix_depth words, then go to LOAD_B.
REQ-030 LOAD_B SHALL accept exactly ap_matrix_depth words, then go to WAIT_OUT.
REQ-031 In each load state, the word counter SHALL increment per accepted word and reset to 0 on the state change; the state changes on the edge that accepts the last word.
REQ-032 The word counter SHALL be 32 bits wide and SHALL never wrap, because depth is bounded by MAX_DEPTH.
REQ-033 WAIT_OUT SHALL go to WAIT_INIT on the first cycle where pe_state==8'h80.
REQ-034 WAIT_INIT SHALL go to IDLE on the first cycle where pe_state==8'h01, pulsing done in that same cycle.
REQ-035 busy SHALL be 1 in every state except IDLE.
REQ-036 ap_matrix_depth SHALL hold its value until the next accepted start.
REQ-037 An in_valid pulse while in_ready==0 SHALL be dropped: no ap_ctrl and no counter change.
REQ-038 Gaps in in_valid mid-phase SHALL stall the phase without losing count.

Reset
REQ-039 While rst==1, asynchronously: state=IDLE, counter=0, in_ready=0, ap_start=0, ap_ctrl=0, col_data=0, ap_matrix_depth=0, busy=0, done=0, err=0.
REQ-040 A reset mid-job SHALL abandon the job; after rst falls, the feeder SHALL wait for a new start and drive no stray ap_ctrl.

Verification
REQ-041 Scenario: ARRAY_SIZE=16, start with cfg_depth=4, 24 back-to-back words 1..24 -> ap_ctrl high 24 cycles; ap_start high for words 1..16; in_ready falls after word 24; state is WAIT_OUT.
REQ-042 Scenario: after REQ-041, pe_state=8'h80 then 8'h01 -> done pulses once in the 8'h01 cycle, busy falls, ap_matrix_depth stays 4.
REQ-043 Scenario: cfg_depth=0, then cfg_depth=8001 -> err pulses each time, busy stays 0, no ap_ctrl.
REQ-044 Scenario: depth=2, in_valid toggling 1/0 -> ap_ctrl exactly 20 pulses, each one cycle after its accept; col_data holds between pulses.
REQ-045 Scenario: rst asserted during LOAD_A word 3 -> all outputs 0 immediately; a fresh start with depth=1 completes a full 18-word load.
REQ-046 Scenario: start asserted during LOAD_B -> ignored; ap_matrix_depth and the counter are unchanged.
